chess_game_clock: RTL and testbench

Parametrised multi-player chess clock that counts down each player's remaining time, applies a per-move Fischer increment, detects flag fall, and drives three active-low seven-segment digits (M:SS) per player. It sits inside the chess engine beside the board/LCD logic. It consumes the debounced start/stop switch and a move-completed pulse from the move-lock logic. It generalises the fixed two-player white/black timer to PLAYERS channels with configurable base time, increment and tick rate.

---
 rtl/chess_game_clock.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_chess_game_clock.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_game_clock.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// chess_game_clock
//
// Multi-player chess clock. Each player owns three BCD digits (M:TU). The
// active player's digits count down once per CLOCK_FREQ cycles while running.
// A Fischer increment is credited to the player who just moved, one second
// per cycle. A player reaching 0:00 raises its flag and freezes the game.
//
// Ports
//   clock        system clock
//   globalReset  asynchronous active-low reset
//   start        level: 1 = run, 0 = pause
//   moveDone     one-cycle pulse: active player finished a move
//   newGame      one-cycle synchronous pulse: reload all clocks, go idle
//   activePlayer index of the player whose clock is running
//   running      high while the game state is RUN
//   incBusy      high while an increment is being credited
//   flagFall     one-hot per player, set when that player reached 0:00
//   minsSeg      active-low {g..a} segments, player p in [7p+6:7p]
//   tensSeg      same layout, tens-of-seconds digit
//   unitsSeg     same layout, units-of-seconds digit
// -----------------------------------------------------------------------------
module chess_game_clock #(
    parameter int CLOCK_FREQ        = 50000000,
    parameter int PLAYERS           = 2,
    parameter int BASE_MINS         = 5,
    parameter int BASE_SECS         = 0,
    parameter int INCREMENT_SECONDS = 0
) (
    input  logic                       clock,
    input  logic                       globalReset,
    input  logic                       start,
    input  logic                       moveDone,
    input  logic                       newGame,
    output logic [$clog2(PLAYERS)-1:0] activePlayer,
    output logic                       running,
    output logic                       incBusy,
    output logic [PLAYERS-1:0]         flagFall,
    output logic [7*PLAYERS-1:0]       minsSeg,
    output logic [7*PLAYERS-1:0]       tensSeg,
    output logic [7*PLAYERS-1:0]       unitsSeg
);

    // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Subtract one second from {M,T,U}; 0:00 stays at 0:00 so it can only flag.
    function automatic logic [11:0] bcd_dec(input logic [11:0] tv);
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] u;
        m = tv[11:8];
        t = tv[7:4];
        u = tv[3:0];
        if (tv == 12'h000) begin
            u = 4'd0;
        end else if (u != 4'd0) begin
            u = u - 4'd1;
        end else if (t != 4'd0) begin
            u = 4'd9;
            t = t - 4'd1;
        end else begin
            u = 4'd9;
            t = 4'd5;
            m = m - 4'd1;
        end
        return {m, t, u};
    endfunction

    // Add one second to {M,T,U}, saturating at 9:59.
    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] tv);
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] u;
        m = tv[11:8];
        t = tv[7:4];
        u = tv[3:0];
        if (tv == 12'h959) begin
            u = 4'd9;
        end else if (u != 4'd9) begin
            u = u + 4'd1;
        end else if (t != 4'd5) begin
            u = 4'd0;
            t = t + 4'd1;
        end else begin
            u = 4'd0;
            t = 4'd0;
            m = m + 4'd1;
        end
        return {m, t, u};
    endfunction

    localparam int              PW          = $clog2(PLAYERS);
    localparam int              PRW         = $clog2(CLOCK_FREQ);
    localparam logic [PRW-1:0]  PRESC_LAST  = PRW'(CLOCK_FREQ - 1);
    localparam logic [PW-1:0]   LAST_PLAYER = PW'(PLAYERS - 1);
    localparam logic [5:0]      INC_LOAD    = 6'(INCREMENT_SECONDS);
    localparam logic [3:0]      BASE_M      = 4'(BASE_MINS);
    localparam logic [3:0]      BASE_T      = 4'(BASE_SECS / 10);
    localparam logic [3:0]      BASE_U      = 4'(BASE_SECS % 10);
    localparam logic [6:0]      SEG_BASE_M  = seg7(BASE_M);
    localparam logic [6:0]      SEG_BASE_T  = seg7(BASE_T);
    localparam logic [6:0]      SEG_BASE_U  = seg7(BASE_U);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_FLAGGED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PRW-1:0]       presc_q, presc_d;
    logic [PW-1:0]        active_q, active_d;
    logic [PLAYERS-1:0]   flag_q, flag_d;
    logic                 inc_busy_q, inc_busy_d;
    logic [5:0]           inc_cnt_q, inc_cnt_d;
    logic [PW-1:0]        inc_player_q, inc_player_d;
    logic                 running_q, running_d;
    logic [3:0]           mins_q  [PLAYERS];
    logic [3:0]           mins_d  [PLAYERS];
    logic [3:0]           tens_q  [PLAYERS];
    logic [3:0]           tens_d  [PLAYERS];
    logic [3:0]           units_q [PLAYERS];
    logic [3:0]           units_d [PLAYERS];
    logic [7*PLAYERS-1:0] mins_seg_q, mins_seg_d;
    logic [7*PLAYERS-1:0] tens_seg_q, tens_seg_d;
    logic [7*PLAYERS-1:0] units_seg_q, units_seg_d;

    logic                 tick_s;
    logic                 expire_s;
    logic                 accept_s;
    logic [11:0]          active_time_s;
    logic [11:0]          dec_time_s;

    // Next-state logic: game FSM, prescaler, countdown, move handling, increment.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        active_d     = active_q;
        flag_d       = flag_q;
        inc_busy_d   = inc_busy_q;
        inc_cnt_d    = inc_cnt_q;
        inc_player_d = inc_player_q;
        for (int p = 0; p < PLAYERS; p++) begin
            mins_d[p]  = mins_q[p];
            tens_d[p]  = tens_q[p];
            units_d[p] = units_q[p];
        end

        tick_s        = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
        active_time_s = 12'h000;
        for (int p = 0; p < PLAYERS; p++) begin
            active_time_s = (PW'(p) == active_q) ? {mins_q[p], tens_q[p], units_q[p]}
                                                 : active_time_s;
        end
        dec_time_s = bcd_dec(active_time_s);
        // A tick that lands on 0:00 wins over a move in the same cycle.
        expire_s   = tick_s && (dec_time_s == 12'h000);
        accept_s   = (state_q == ST_RUN) && moveDone && !inc_busy_q && !expire_s;

        if (newGame) begin
            state_d      = ST_IDLE;
            presc_d      = '0;
            active_d     = '0;
            flag_d       = '0;
            inc_busy_d   = 1'b0;
            inc_cnt_d    = 6'd0;
            inc_player_d = '0;
            for (int p = 0; p < PLAYERS; p++) begin
                mins_d[p]  = BASE_M;
                tens_d[p]  = BASE_T;
                units_d[p] = BASE_U;
            end
        end else begin
            case (state_q)
                ST_IDLE:    state_d = start ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (expire_s) begin
                        state_d = ST_FLAGGED;
                    end else if (!start) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSED:  state_d = start ? ST_RUN : ST_PAUSED;
                ST_FLAGGED: state_d = ST_FLAGGED;
                default:    state_d = ST_IDLE;
            endcase

            // Prescaler only advances in RUN; its count survives a pause.
            if (state_q == ST_RUN) begin
                if (tick_s || accept_s) begin
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PRW'(1);
                end
            end else begin
                presc_d = presc_q;
            end

            // Countdown of the (pre-move) active player.
            if (tick_s) begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (PW'(p) == active_q) begin
                        {mins_d[p], tens_d[p], units_d[p]} = dec_time_s;
                        flag_d[p] = flag_q[p] | expire_s;
                    end else begin
                        flag_d[p] = flag_q[p];
                    end
                end
            end else begin
                flag_d = flag_q;
            end

            if (accept_s) begin
                active_d = (active_q == LAST_PLAYER) ? '0 : active_q + PW'(1);
                if (INCREMENT_SECONDS > 0) begin
                    inc_player_d = active_q;
                    inc_busy_d   = 1'b1;
                    inc_cnt_d    = INC_LOAD;
                end else begin
                    inc_busy_d   = 1'b0;
                end
            end else begin
                active_d = active_q;
            end

            // Increment crediting; discarded when the game flags. It builds on
            // the post-tick digits so both updates compose in one cycle.
            if (expire_s) begin
                inc_busy_d = 1'b0;
                inc_cnt_d  = 6'd0;
            end else if (inc_busy_q) begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (PW'(p) == inc_player_q) begin
                        {mins_d[p], tens_d[p], units_d[p]} =
                            bcd_inc_sat({mins_d[p], tens_d[p], units_d[p]});
                    end else begin
                        units_d[p] = units_d[p];
                    end
                end
                inc_cnt_d  = inc_cnt_q - 6'd1;
                inc_busy_d = (inc_cnt_q != 6'd1);
            end else begin
                inc_cnt_d = inc_cnt_d;
            end
        end
    end

    // Output staging: running follows the next state, segments follow digits.
    always_comb begin
        running_d   = (state_d == ST_RUN);
        mins_seg_d  = '1;
        tens_seg_d  = '1;
        units_seg_d = '1;
        for (int p = 0; p < PLAYERS; p++) begin
            mins_seg_d[7*p +: 7]  = seg7(mins_q[p]);
            tens_seg_d[7*p +: 7]  = seg7(tens_q[p]);
            units_seg_d[7*p +: 7] = seg7(units_q[p]);
        end
    end

    // State and output registers with asynchronous reset to the base position.
    always_ff @(posedge clock or negedge globalReset) begin
        if (!globalReset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            active_q     <= '0;
            flag_q       <= '0;
            inc_busy_q   <= 1'b0;
            inc_cnt_q    <= 6'd0;
            inc_player_q <= '0;
            running_q    <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                mins_q[p]  <= BASE_M;
                tens_q[p]  <= BASE_T;
                units_q[p] <= BASE_U;
            end
            mins_seg_q   <= {PLAYERS{SEG_BASE_M}};
            tens_seg_q   <= {PLAYERS{SEG_BASE_T}};
            units_seg_q  <= {PLAYERS{SEG_BASE_U}};
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            active_q     <= active_d;
            flag_q       <= flag_d;
            inc_busy_q   <= inc_busy_d;
            inc_cnt_q    <= inc_cnt_d;
            inc_player_q <= inc_player_d;
            running_q    <= running_d;
            for (int p = 0; p < PLAYERS; p++) begin
                mins_q[p]  <= mins_d[p];
                tens_q[p]  <= tens_d[p];
                units_q[p] <= units_d[p];
            end
            mins_seg_q   <= mins_seg_d;
            tens_seg_q   <= tens_seg_d;
            units_seg_q  <= units_seg_d;
        end
    end

    assign activePlayer = active_q;
    assign running      = running_q;
    assign incBusy      = inc_busy_q;
    assign flagFall     = flag_q;
    assign minsSeg      = mins_seg_q;
    assign tensSeg      = tens_seg_q;
    assign unitsSeg     = units_seg_q;

endmodule

// File: tb/tb_chess_game_clock.sv
`timescale 1ns/1ps
// Directed bench for chess_game_clock using three small configurations:
//   A: 2 players, 0:03 base, no increment      (countdown, flag, pause, newGame)
//   B: 3 players, 9:58 base, 3 s increment     (increment, rotation, async reset)
//   C: 2 players, 1:00 base, no increment      (minute borrow)
module tb_chess_game_clock;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start_a, move_a, ng_a, run_a, busy_a;
    logic [0:0]  act_a;
    logic [1:0]  flag_a;
    logic [13:0] mseg_a, tseg_a, useg_a;

    logic        start_b, move_b, ng_b, run_b, busy_b;
    logic [1:0]  act_b;
    logic [2:0]  flag_b;
    logic [20:0] mseg_b, tseg_b, useg_b;

    logic        start_c, move_c, ng_c, run_c, busy_c;
    logic [0:0]  act_c;
    logic [1:0]  flag_c;
    logic [13:0] mseg_c, tseg_c, useg_c;

    chess_game_clock #(.CLOCK_FREQ(4), .PLAYERS(2), .BASE_MINS(0), .BASE_SECS(3),
                       .INCREMENT_SECONDS(0)) u_a (
        .clock(clk), .globalReset(rst_n), .start(start_a), .moveDone(move_a),
        .newGame(ng_a), .activePlayer(act_a), .running(run_a), .incBusy(busy_a),
        .flagFall(flag_a), .minsSeg(mseg_a), .tensSeg(tseg_a), .unitsSeg(useg_a));

    chess_game_clock #(.CLOCK_FREQ(4), .PLAYERS(3), .BASE_MINS(9), .BASE_SECS(58),
                       .INCREMENT_SECONDS(3)) u_b (
        .clock(clk), .globalReset(rst_n), .start(start_b), .moveDone(move_b),
        .newGame(ng_b), .activePlayer(act_b), .running(run_b), .incBusy(busy_b),
        .flagFall(flag_b), .minsSeg(mseg_b), .tensSeg(tseg_b), .unitsSeg(useg_b));

    chess_game_clock #(.CLOCK_FREQ(4), .PLAYERS(2), .BASE_MINS(1), .BASE_SECS(0),
                       .INCREMENT_SECONDS(0)) u_c (
        .clock(clk), .globalReset(rst_n), .start(start_c), .moveDone(move_c),
        .newGame(ng_c), .activePlayer(act_c), .running(run_c), .incBusy(busy_c),
        .flagFall(flag_c), .minsSeg(mseg_c), .tensSeg(tseg_c), .unitsSeg(useg_c));

    // Reference active-low digit patterns {g..a}.
    function automatic logic [6:0] seg_exp(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL rst_act_a: got %h want 0", act_a); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL rst_run_a: got %b want 0", run_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL rst_busy_b: got %b want 0", busy_b); end
        checks++; if (flag_a !== 2'b00) begin errors++; $display("FAIL rst_flag_a: got %b want 00", flag_a); end
        checks++; if (useg_a !== {seg_exp(3), seg_exp(3)}) begin errors++; $display("FAIL rst_useg_a: got %b want %b", useg_a, {seg_exp(3), seg_exp(3)}); end
        checks++; if (mseg_c !== {seg_exp(1), seg_exp(1)}) begin errors++; $display("FAIL rst_mseg_c: got %b want %b", mseg_c, {seg_exp(1), seg_exp(1)}); end
        checks++; if (tseg_b[6:0] !== seg_exp(5)) begin errors++; $display("FAIL rst_tseg_b: got %b want %b", tseg_b[6:0], seg_exp(5)); end
        rst_n = 1'b1;
        step(1);
    endtask

    // 1:00 -> 0:59 exercises both the tens wrap and the minute borrow.
    task automatic test_borrow();
        start_c = 1'b1;
        step(5);
        checks++; if (mseg_c[6:0] !== seg_exp(1)) begin errors++; $display("FAIL borrow_early_m: got %b want %b", mseg_c[6:0], seg_exp(1)); end
        step(1);
        checks++; if (mseg_c[6:0] !== seg_exp(0)) begin errors++; $display("FAIL borrow_m: got %b want %b", mseg_c[6:0], seg_exp(0)); end
        checks++; if (tseg_c[6:0] !== 7'b0010010) begin errors++; $display("FAIL borrow_t: got %b want 0010010", tseg_c[6:0]); end
        checks++; if (useg_c[6:0] !== 7'b0010000) begin errors++; $display("FAIL borrow_u: got %b want 0010000", useg_c[6:0]); end
        checks++; if (mseg_c[13:7] !== seg_exp(1)) begin errors++; $display("FAIL borrow_p1_m: got %b want %b", mseg_c[13:7], seg_exp(1)); end
        start_c = 1'b0;
    endtask

    task automatic test_countdown();
        start_a = 1'b1;
        step(1);
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL cd_running: got %b want 1", run_a); end
        step(5);
        checks++; if (useg_a[6:0] !== seg_exp(2)) begin errors++; $display("FAIL cd_002: got %b want %b", useg_a[6:0], seg_exp(2)); end
        step(4);
        checks++; if (useg_a[6:0] !== seg_exp(1)) begin errors++; $display("FAIL cd_001: got %b want %b", useg_a[6:0], seg_exp(1)); end
        step(2);
        checks++; if (flag_a !== 2'b00) begin errors++; $display("FAIL cd_noflag: got %b want 00", flag_a); end
        step(1);
        checks++; if (flag_a !== 2'b01) begin errors++; $display("FAIL cd_flag: got %b want 01", flag_a); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL cd_flag_run: got %b want 0", run_a); end
        step(1);
        checks++; if (useg_a !== {seg_exp(3), seg_exp(0)}) begin errors++; $display("FAIL cd_000: got %b want %b", useg_a, {seg_exp(3), seg_exp(0)}); end
        move_a = 1'b1;
        step(1);
        move_a = 1'b0;
        checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL cd_move_ignored: got %h want 0", act_a); end
        step(8);
        checks++; if (flag_a !== 2'b01 || run_a !== 1'b0) begin errors++; $display("FAIL cd_terminal: got flag %b run %b want 01 0", flag_a, run_a); end
    endtask

    task automatic test_new_game_pause();
        start_a = 1'b0;
        ng_a    = 1'b1;
        step(1);
        ng_a    = 1'b0;
        checks++; if (flag_a !== 2'b00) begin errors++; $display("FAIL ng_flag: got %b want 00", flag_a); end
        step(1);
        checks++; if (useg_a !== {seg_exp(3), seg_exp(3)}) begin errors++; $display("FAIL ng_reload: got %b want %b", useg_a, {seg_exp(3), seg_exp(3)}); end
        // Run two edges so the prescaler holds 2 when paused.
        start_a = 1'b1;
        step(2);
        start_a = 1'b0;
        step(1);
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL pause_run: got %b want 0", run_a); end
        step(100);
        checks++; if (useg_a[6:0] !== seg_exp(3)) begin errors++; $display("FAIL pause_hold: got %b want %b", useg_a[6:0], seg_exp(3)); end
        start_a = 1'b1;
        step(1);
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL resume_run: got %b want 1", run_a); end
        step(2);
        checks++; if (useg_a[6:0] !== seg_exp(3)) begin errors++; $display("FAIL resume_early: got %b want %b", useg_a[6:0], seg_exp(3)); end
        step(1);
        checks++; if (useg_a[6:0] !== seg_exp(2)) begin errors++; $display("FAIL resume_tick: got %b want %b", useg_a[6:0], seg_exp(2)); end
        move_a = 1'b1;
        step(1);
        move_a = 1'b0;
        checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL move_a: got %h want 1", act_a); end
        start_a = 1'b0;
        ng_a    = 1'b1;
        step(1);
        ng_a    = 1'b0;
        checks++; if (act_a !== 1'b0 || run_a !== 1'b0) begin errors++; $display("FAIL ng2_idle: got act %h run %b want 0 0", act_a, run_a); end
        step(1);
        checks++; if (useg_a !== {seg_exp(3), seg_exp(3)}) begin errors++; $display("FAIL ng2_reload: got %b want %b", useg_a, {seg_exp(3), seg_exp(3)}); end
    endtask

    // Move coinciding with a non-final tick, then with the flagging tick.
    task automatic test_tick_move_same_cycle();
        start_a = 1'b1;
        step(8);
        move_a = 1'b1;
        step(1);
        move_a = 1'b0;
        checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL tm_both_act: got %h want 1", act_a); end
        step(1);
        checks++; if (useg_a !== {seg_exp(3), seg_exp(1)}) begin errors++; $display("FAIL tm_both_digits: got %b want %b", useg_a, {seg_exp(3), seg_exp(1)}); end
        step(10);
        checks++; if (useg_a[13:7] !== seg_exp(1) || flag_a !== 2'b00) begin errors++; $display("FAIL tm_p1_001: got seg %b flag %b want %b 00", useg_a[13:7], flag_a, seg_exp(1)); end
        move_a = 1'b1;
        step(1);
        move_a = 1'b0;
        checks++; if (flag_a !== 2'b10) begin errors++; $display("FAIL tm_flag: got %b want 10", flag_a); end
        checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL tm_act_kept: got %h want 1", act_a); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL tm_run: got %b want 0", run_a); end
        start_a = 1'b0;
    endtask

    task automatic test_increment();
        start_b = 1'b1;
        step(1);
        checks++; if (run_b !== 1'b1) begin errors++; $display("FAIL inc_run: got %b want 1", run_b); end
        move_b = 1'b1;
        step(1);
        checks++; if (act_b !== 2'd1 || busy_b !== 1'b1) begin errors++; $display("FAIL inc_start: got act %h busy %b want 1 1", act_b, busy_b); end
        // moveDone stays high for one more edge: a second move while busy.
        step(1);
        move_b = 1'b0;
        checks++; if (act_b !== 2'd1 || busy_b !== 1'b1) begin errors++; $display("FAIL inc_second_move: got act %h busy %b want 1 1", act_b, busy_b); end
        step(1);
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL inc_busy3: got %b want 1", busy_b); end
        checks++; if ({mseg_b[6:0], tseg_b[6:0], useg_b[6:0]} !== {seg_exp(9), seg_exp(5), seg_exp(9)}) begin errors++; $display("FAIL inc_959: got %b want %b", {mseg_b[6:0], tseg_b[6:0], useg_b[6:0]}, {seg_exp(9), seg_exp(5), seg_exp(9)}); end
        step(1);
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL inc_done: got %b want 0", busy_b); end
        checks++; if ({mseg_b[6:0], tseg_b[6:0], useg_b[6:0]} !== {seg_exp(9), seg_exp(5), seg_exp(9)}) begin errors++; $display("FAIL inc_sat: got %b want %b", {mseg_b[6:0], tseg_b[6:0], useg_b[6:0]}, {seg_exp(9), seg_exp(5), seg_exp(9)}); end
        step(2);
        checks++; if (useg_b[13:7] !== seg_exp(7)) begin errors++; $display("FAIL inc_p1_tick: got %b want %b", useg_b[13:7], seg_exp(7)); end
        checks++; if (useg_b[20:14] !== seg_exp(8)) begin errors++; $display("FAIL inc_p2_idle: got %b want %b", useg_b[20:14], seg_exp(8)); end
    endtask

    task automatic test_rotation();
        move_b = 1'b1;
        step(1);
        move_b = 1'b0;
        checks++; if (act_b !== 2'd2) begin errors++; $display("FAIL rot_2: got %h want 2", act_b); end
        step(4);
        move_b = 1'b1;
        step(1);
        move_b = 1'b0;
        checks++; if (act_b !== 2'd0) begin errors++; $display("FAIL rot_wrap: got %h want 0", act_b); end
        step(4);
        move_b = 1'b1;
        step(1);
        move_b = 1'b0;
        checks++; if (act_b !== 2'd1 || busy_b !== 1'b1) begin errors++; $display("FAIL rot_1: got act %h busy %b want 1 1", act_b, busy_b); end
    endtask

    // Reset asserted mid-cycle while an increment is in flight.
    task automatic test_reset_mid_increment();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (act_b !== 2'd0 || busy_b !== 1'b0 || run_b !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got act %h busy %b run %b want 0 0 0", act_b, busy_b, run_b); end
        checks++; if (useg_b !== {seg_exp(8), seg_exp(8), seg_exp(8)}) begin errors++; $display("FAIL arst_useg: got %b want %b", useg_b, {seg_exp(8), seg_exp(8), seg_exp(8)}); end
        checks++; if (mseg_b !== {seg_exp(9), seg_exp(9), seg_exp(9)}) begin errors++; $display("FAIL arst_mseg: got %b want %b", mseg_b, {seg_exp(9), seg_exp(9), seg_exp(9)}); end
        checks++; if (flag_a !== 2'b00 || flag_b !== 3'b000) begin errors++; $display("FAIL arst_flags: got %b %b want 00 000", flag_a, flag_b); end
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start_a = 1'b0; move_a = 1'b0; ng_a = 1'b0;
        start_b = 1'b0; move_b = 1'b0; ng_b = 1'b0;
        start_c = 1'b0; move_c = 1'b0; ng_c = 1'b0;
        test_reset();
        test_borrow();
        test_countdown();
        test_new_game_pause();
        test_tick_move_same_cycle();
        test_increment();
        test_rotation();
        test_reset_mid_increment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
